// File: rtl/cnn_pkg.sv
// Dimensions, widths and loader states shared with conv_layer.
package cnn_pkg;
  localparam int DATA_X      = 28;
  localparam int DATA_Y      = 28;
  localparam int DATA_SIZE   = 32;
  localparam int WEIGHT_X    = 5;
  localparam int WEIGHT_Y    = 5;
  localparam int WEIGHT_SIZE = 32;
  localparam int NUM_KERNELS = 8;

  typedef enum logic [1:0] {LOAD_W, LOAD_D, CONV, HOLD} state_t;

  // Index width for a counter of n positions; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_index_counter.sv
// Three-level wrapping index counter (outer/mid/inner, inner fastest); advances one step per inc.
// done is combinational and flags the final index; the step taken from it wraps all levels to 0.
module conv_index_counter
  import cnn_pkg::*;
#(
  parameter int OUTER_N = 1,
  parameter int MID_N   = 1,
  parameter int INNER_N = 1,
  parameter int OW      = idx_w(OUTER_N),
  parameter int MW      = idx_w(MID_N),
  parameter int IW      = idx_w(INNER_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [OW-1:0] outer,
  output logic [MW-1:0] mid,
  output logic [IW-1:0] inner,
  output logic          done
);
  localparam logic [OW-1:0] OUTER_MAX = OW'(OUTER_N - 1);
  localparam logic [MW-1:0] MID_MAX   = MW'(MID_N - 1);
  localparam logic [IW-1:0] INNER_MAX = IW'(INNER_N - 1);

  logic outer_last, mid_last, inner_last;

  assign outer_last = (outer == OUTER_MAX);
  assign mid_last   = (mid == MID_MAX);
  assign inner_last = (inner == INNER_MAX);
  assign done       = outer_last && mid_last && inner_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      outer <= '0;
      mid   <= '0;
      inner <= '0;
    end else if (inc) begin
      if (!inner_last) begin
        inner <= inner + 1'b1;
      end else begin
        inner <= '0;
        if (!mid_last) begin
          mid <= mid + 1'b1;
        end else begin
          mid   <= '0;
          outer <= outer_last ? '0 : outer + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/conv_input_loader.sv
// Loads 8x5x5 weights then a 28x28 image from a valid/ready stream into conv_layer's arrays.
// Stream is stalled (in_ready=0) from the last pixel until result_ack is seen in HOLD.
module conv_input_loader
  import cnn_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_data,
  input  logic                          in_last,
  output logic [DATA_SIZE-1:0]          data   [DATA_X][DATA_Y],
  output logic signed [WEIGHT_SIZE-1:0] weight [NUM_KERNELS][WEIGHT_X][WEIGHT_Y],
  output logic                          conv_enable,
  input  logic                          conv_done,
  output logic                          results_valid,
  input  logic                          result_ack,
  input  logic                          reload_weights,
  output logic                          weights_loaded,
  output logic                          frame_err
);
  state_t state_q, state_d;

  logic accept, w_inc, d_inc, w_done, d_done, sec_last;
  logic [idx_w(NUM_KERNELS)-1:0] w_k;
  logic [idx_w(WEIGHT_X)-1:0]    w_i;
  logic [idx_w(WEIGHT_Y)-1:0]    w_j;
  logic [0:0]                    d_outer_unused;
  logic [idx_w(DATA_X)-1:0]      d_x;
  logic [idx_w(DATA_Y)-1:0]      d_y;

  assign in_ready      = (state_q == LOAD_W) || (state_q == LOAD_D);
  assign conv_enable   = (state_q == CONV) || (state_q == HOLD);
  assign results_valid = (state_q == HOLD);

  assign accept   = in_valid && in_ready;
  assign w_inc    = accept && (state_q == LOAD_W);
  assign d_inc    = accept && (state_q == LOAD_D);
  assign sec_last = (state_q == LOAD_W) ? w_done : d_done;

  conv_index_counter #(
    .OUTER_N(NUM_KERNELS), .MID_N(WEIGHT_X), .INNER_N(WEIGHT_Y)
  ) u_w_cnt (
    .clk(clk), .rst(rst), .inc(w_inc),
    .outer(w_k), .mid(w_i), .inner(w_j), .done(w_done)
  );

  conv_index_counter #(
    .OUTER_N(1), .MID_N(DATA_X), .INNER_N(DATA_Y)
  ) u_d_cnt (
    .clk(clk), .rst(rst), .inc(d_inc),
    .outer(d_outer_unused), .mid(d_x), .inner(d_y), .done(d_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD_W;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_W: if (w_inc && w_done) state_d = LOAD_D;
      LOAD_D: if (d_inc && d_done) state_d = CONV;
      CONV:   if (conv_done) state_d = HOLD;
      HOLD:   if (result_ack) state_d = reload_weights ? LOAD_W : LOAD_D;
      default: state_d = LOAD_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weights_loaded <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      if (w_inc && w_done)
        weights_loaded <= 1'b1;
      else if ((state_q == HOLD) && result_ack && reload_weights)
        weights_loaded <= 1'b0;
      // Counters alone end a section; in_last is only cross-checked against them.
      if (accept && (in_last != sec_last))
        frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_KERNELS; k++)
        for (int i = 0; i < WEIGHT_X; i++)
          for (int j = 0; j < WEIGHT_Y; j++)
            weight[k][i][j] <= '0;
      for (int x = 0; x < DATA_X; x++)
        for (int y = 0; y < DATA_Y; y++)
          data[x][y] <= '0;
    end else begin
      if (w_inc) weight[w_k][w_i][w_j] <= in_data;
      if (d_inc) data[d_x][d_y] <= in_data;
    end
  end
endmodule

// File: tb/tb_conv_input_loader.sv
// Directed bench for conv_input_loader: loading, handshake stalls, framing and reset behaviour.
module tb_conv_input_loader;
  import cnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [31:0] data   [DATA_X][DATA_Y];
  logic signed [31:0] weight [NUM_KERNELS][WEIGHT_X][WEIGHT_Y];
  logic        conv_enable, conv_done, results_valid, result_ack, reload_weights;
  logic        weights_loaded, frame_err;

  int checks = 0;
  int errors = 0;

  conv_input_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .data(data), .weight(weight),
    .conv_enable(conv_enable), .conv_done(conv_done),
    .results_valid(results_valid), .result_ack(result_ack),
    .reload_weights(reload_weights), .weights_loaded(weights_loaded),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic send(input int d, input bit last, input bit bubble);
    int t;
    if (bubble && ($urandom_range(0, 9) < 3)) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Words [from,to] of a section of length sec_len; in_last on word extra and (if fin) the final word.
  task automatic send_sec(input int sec_len, input int from, input int to, input int base,
                          input int extra, input bit fin, input bit bub);
    for (int n = from; n <= to; n++)
      send(base + n, (n == extra) || (fin && n == sec_len - 1), bub);
  endtask

  task automatic scan_w(input string tag, input int base);
    int bad = 0;
    for (int k = 0; k < NUM_KERNELS; k++)
      for (int i = 0; i < WEIGHT_X; i++)
        for (int j = 0; j < WEIGHT_Y; j++)
          if (weight[k][i][j] !== 32'(base + k*25 + i*5 + j)) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic scan_d(input string tag, input int base);
    int bad = 0;
    for (int x = 0; x < DATA_X; x++)
      for (int y = 0; y < DATA_Y; y++)
        if (data[x][y] !== 32'(base + x*28 + y)) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  task automatic run_conv();
    chk("ce_after_last", 32'(conv_enable), 32'd1);
    chk("rdy_in_conv", 32'(in_ready), 32'd0);
    chk("rv_in_conv", 32'(results_valid), 32'd0);
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("rv_in_hold", 32'(results_valid), 32'd1);
    chk("state_hold", 32'(dut.state_q), 32'(HOLD));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int hi;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    conv_done = 1'b0; result_ack = 1'b0; reload_weights = 1'b0;
    do_reset();

    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_ce", 32'(conv_enable), 32'd0);
    chk("rst_rv", 32'(results_valid), 32'd0);
    chk("rst_wl", 32'(weights_loaded), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(LOAD_W));

    // Basic load: weights w=idx, pixels p=n.
    send_sec(200, 0, 199, 0, -1, 1'b1, 1'b0);
    chk("t1_wl", 32'(weights_loaded), 32'd1);
    chk("t1_state_d", 32'(dut.state_q), 32'(LOAD_D));
    send_sec(784, 0, 783, 0, -1, 1'b1, 1'b0);
    run_conv();
    chk("t1_w744", weight[7][4][4], 32'd199);
    chk("t1_w321", weight[3][2][1], 32'd86);
    chk("t1_d2727", data[27][27], 32'd783);
    chk("t1_d105", data[10][5], 32'd285);
    scan_w("t1_wscan", 0);
    scan_d("t1_dscan", 0);
    chk("t1_fe", 32'(frame_err), 32'd0);

    // Stalled HOLD: stream pushes, nothing moves; lone reload_weights ignored.
    in_valid = 1'b1; in_data = 32'hdeadbeef; reload_weights = 1'b1;
    hi = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (in_ready) hi++;
    end
    in_valid = 1'b0; reload_weights = 1'b0;
    chk("t2_rdy_low", 32'(hi), 32'd0);
    chk("t2_still_hold", 32'(dut.state_q), 32'(HOLD));
    scan_w("t2_wscan", 0);
    scan_d("t2_dscan", 0);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("t2_state_d", 32'(dut.state_q), 32'(LOAD_D));
    chk("t2_wl", 32'(weights_loaded), 32'd1);
    chk("t2_rdy", 32'(in_ready), 32'd1);
    chk("t2_ce", 32'(conv_enable), 32'd0);
    chk("t2_rv", 32'(results_valid), 32'd0);

    // Bubbled pixel stream; stray ack during CONV ignored.
    send_sec(784, 0, 783, 0, -1, 1'b1, 1'b1);
    chk("t3_ce", 32'(conv_enable), 32'd1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("t3_ack_in_conv", 32'(dut.state_q), 32'(CONV));
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("t3_rv", 32'(results_valid), 32'd1);
    scan_d("t3_dscan", 0);
    scan_w("t3_wscan", 0);

    // Reload weights with new values.
    result_ack = 1'b1; reload_weights = 1'b1;
    tick();
    result_ack = 1'b0; reload_weights = 1'b0;
    chk("t6_wl_clr", 32'(weights_loaded), 32'd0);
    chk("t6_state_w", 32'(dut.state_q), 32'(LOAD_W));
    send_sec(200, 0, 199, 1000, -1, 1'b1, 1'b1);
    chk("t6_wl", 32'(weights_loaded), 32'd1);
    scan_w("t6_wscan", 1000);
    send_sec(784, 0, 783, 5000, -1, 1'b1, 1'b0);
    run_conv();
    scan_d("t6_dscan", 5000);
    chk("t6_fe", 32'(frame_err), 32'd0);

    // Early in_last on weight 100 flags but does not end the section.
    do_reset();
    send_sec(200, 0, 150, 0, 100, 1'b1, 1'b0);
    chk("t4_fe", 32'(frame_err), 32'd1);
    chk("t4_not_early", 32'(dut.state_q), 32'(LOAD_W));
    send_sec(200, 151, 199, 0, 100, 1'b1, 1'b0);
    chk("t4_state_d", 32'(dut.state_q), 32'(LOAD_D));
    scan_w("t4_wscan", 0);

    // Reset after 400 pixels.
    send_sec(784, 0, 399, 0, -1, 1'b1, 1'b0);
    chk("t5_fe_sticky", 32'(frame_err), 32'd1);
    chk("t5_d_mid", data[14][7], 32'd399);
    rst = 1'b1;
    tick();
    chk("t5_rdy", 32'(in_ready), 32'd1);
    chk("t5_state", 32'(dut.state_q), 32'(LOAD_W));
    chk("t5_fe", 32'(frame_err), 32'd0);
    chk("t5_wl", 32'(weights_loaded), 32'd0);
    chk("t5_ce", 32'(conv_enable), 32'd0);
    chk("t5_d", data[14][7], 32'd0);
    chk("t5_w", weight[7][4][4], 32'd0);
    rst = 1'b0;
    tick();

    // Missing in_last on the final weight word.
    send_sec(200, 0, 199, 0, -1, 1'b0, 1'b0);
    chk("t4b_fe", 32'(frame_err), 32'd1);
    chk("t4b_state_d", 32'(dut.state_q), 32'(LOAD_D));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
